ifetch_unit: RTL and testbench

Instruction fetch unit. Owns the PC, drives the synchronous instruction memory and presents the fetched instruction to the decoder. Supplies `opcplus4`, the JAL link value consumed by the decoder's write-back path. Resolves next-PC from the control and ALU results of the current instruction, and handles stall, cold-start priming and misaligned-target faults.

---
 rtl/ifetch_unit_pkg.sv | 25 ++
 rtl/ifetch_unit_if.sv | 55 +++++
 rtl/ifetch_unit_pc_next_sel.sv | 42 ++++
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, jump-field range,
// FSM encoding and the J/JAL target helper.
package ifetch_unit_pkg;

   localparam int ISA_WIDTH               = 32;
   localparam int IMEM_ADDR_WIDTH_DEFAULT = 14;
   localparam int INDEX_MSB               = 25;
   localparam int INDEX_LSB               = 0;
   localparam int INDEX_W                 = INDEX_MSB - INDEX_LSB + 1;

   localparam logic [ISA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_PRIME = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_e;

   // J/JAL target: keep the 256 MB region of pc+4, splice in the word index.
   function automatic logic [ISA_WIDTH-1:0] jump_target(input logic [3:0]         region,
                                                         input logic [INDEX_W-1:0] index);
      return {region, index, 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Decoder/memory-facing bundle of the fetch unit. Optional counter outputs
// exist only when IFETCH_PERF_CNT_EN is defined.
interface ifetch_unit_if
   import ifetch_unit_pkg::*;
#(
   parameter int IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEFAULT
);
   // Handshake contract: there is no valid/ready pair on the memory side; the
   // memory always returns imem_rdata for imem_addr one cycle later. Toward the
   // decoder, instr_valid qualifies instruction and all control inputs: while
   // instr_valid is 0 the fetch unit ignores stall/branch/jump/jal/jr.
   logic                       stall;
   logic                       branch;
   logic                       nbranch;
   logic                       zero;
   logic                       jmp;
   logic                       jal;
   logic                       jr;
   logic [ISA_WIDTH-1:0]       addr_result;
   logic [ISA_WIDTH-1:0]       read_data_1;
   logic [ISA_WIDTH-1:0]       imem_rdata;
   logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
   logic [ISA_WIDTH-1:0]       instruction;
   logic                       instr_valid;
   logic [ISA_WIDTH-1:0]       pc;
   logic [ISA_WIDTH-1:0]       branch_base_addr;
   logic [ISA_WIDTH-1:0]       opcplus4;
   logic                       fetch_fault;
   state_e                     dbg_state;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0]                fetch_count;
   logic [31:0]                redirect_count;
`endif

   modport master (
      input  stall, branch, nbranch, zero, jmp, jal, jr,
      input  addr_result, read_data_1, imem_rdata,
      output imem_addr, instruction, instr_valid, pc, branch_base_addr,
      output opcplus4, fetch_fault, dbg_state
`ifdef IFETCH_PERF_CNT_EN
      , output fetch_count, redirect_count
`endif
   );

   modport slave (
      output stall, branch, nbranch, zero, jmp, jal, jr,
      output addr_result, read_data_1, imem_rdata,
      input  imem_addr, instruction, instr_valid, pc, branch_base_addr,
      input  opcplus4, fetch_fault, dbg_state
`ifdef IFETCH_PERF_CNT_EN
      , input fetch_count, redirect_count
`endif
   );

endinterface

// File: rtl/ifetch_unit_pc_next_sel.sv
// Combinational next-PC selection: jr > j/jal > taken branch > pc+4, plus the
// misaligned non-sequential target detect.
module ifetch_unit_pc_next_sel
   import ifetch_unit_pkg::*;
(
   input  logic [ISA_WIDTH-1:0] pc_plus4,
   input  logic [INDEX_W-1:0]   instr_index,
   input  logic                 branch,
   input  logic                 nbranch,
   input  logic                 zero,
   input  logic                 jmp,
   input  logic                 jal,
   input  logic                 jr,
   input  logic [ISA_WIDTH-1:0] addr_result,
   input  logic [ISA_WIDTH-1:0] read_data_1,
   output logic [ISA_WIDTH-1:0] next_pc,
   output logic                 misaligned
);

   logic taken;
   logic non_seq;

   assign taken = (branch & zero) | (nbranch & ~zero);

   always_comb begin
      next_pc = pc_plus4;
      non_seq = 1'b1;
      if (jr) begin
         next_pc = read_data_1;
      end else if (jmp | jal) begin
         next_pc = jump_target(pc_plus4[ISA_WIDTH-1:ISA_WIDTH-4], instr_index);
      end else if (taken) begin
         next_pc = addr_result;
      end else begin
         non_seq = 1'b0;
      end
   end

   // The sequential path is always aligned, so only redirects can fault.
   assign misaligned = non_seq & (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register, cold-start priming FSM, stall handling,
// JAL link register and sticky misaligned-target fault.
// Optional perf counters are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int                   IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEFAULT,
   parameter logic [ISA_WIDTH-1:0] RESET_PC        = RESET_PC_DEFAULT
)(
   input  logic          clock,
   input  logic          reset,
   ifetch_unit_if.master bus
);

   state_e               state_q, state_d;
   logic [ISA_WIDTH-1:0] pc_q, pc_d;
   logic [ISA_WIDTH-1:0] opcplus4_q, opcplus4_d;
   logic                 fetch_fault_q, fetch_fault_d;

   logic [ISA_WIDTH-1:0] pc_plus4;
   logic [ISA_WIDTH-1:0] next_pc;
   logic                 misaligned;
   logic                 advance;

   assign pc_plus4 = pc_q + ISA_WIDTH'(4);

   ifetch_unit_pc_next_sel u_pc_next_sel (
      .pc_plus4    (pc_plus4),
      .instr_index (bus.imem_rdata[INDEX_MSB:INDEX_LSB]),
      .branch      (bus.branch),
      .nbranch     (bus.nbranch),
      .zero        (bus.zero),
      .jmp         (bus.jmp),
      .jal         (bus.jal),
      .jr          (bus.jr),
      .addr_result (bus.addr_result),
      .read_data_1 (bus.read_data_1),
      .next_pc     (next_pc),
      .misaligned  (misaligned)
   );

   // A fetch retires on every un-stalled S_RUN edge, including a faulting one.
   assign advance = reset && (state_q == S_RUN) && !bus.stall;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      opcplus4_d    = opcplus4_q;
      fetch_fault_d = fetch_fault_q;
      bus.imem_addr   = pc_q[IMEM_ADDR_WIDTH+1:2];
      bus.instr_valid = 1'b0;
      unique case (state_q)
         S_PRIME: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            bus.instr_valid = 1'b1;
            if (!bus.stall) begin
               // Address the target directly so a redirect costs no bubble.
               bus.imem_addr = next_pc[IMEM_ADDR_WIDTH+1:2];
               if (bus.jal) begin
                  opcplus4_d = pc_plus4;
               end
               if (misaligned) begin
                  state_d       = S_FAULT;
                  fetch_fault_d = 1'b1;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         S_FAULT: begin
            fetch_fault_d = 1'b1;
         end
         default: begin
            state_d = S_PRIME;
         end
      endcase
      if (!reset) begin
         bus.instr_valid = 1'b0;
         bus.imem_addr   = RESET_PC[IMEM_ADDR_WIDTH+1:2];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= S_PRIME;
         pc_q          <= RESET_PC;
         opcplus4_q    <= '0;
         fetch_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         opcplus4_q    <= opcplus4_d;
         fetch_fault_q <= fetch_fault_d;
      end
   end

   assign bus.instruction      = bus.imem_rdata;
   assign bus.pc               = pc_q;
   assign bus.branch_base_addr = pc_plus4;
   assign bus.opcplus4         = opcplus4_q;
   assign bus.fetch_fault      = fetch_fault_q;
   assign bus.dbg_state        = state_q;

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] redirect_count_q, redirect_count_d;

   always_comb begin
      fetch_count_d    = fetch_count_q;
      redirect_count_d = redirect_count_q;
      if (advance) begin
         fetch_count_d = fetch_count_q + 32'd1;
         if (next_pc != pc_plus4) begin
            redirect_count_d = redirect_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_count_q    <= '0;
         redirect_count_q <= '0;
      end else begin
         fetch_count_q    <= fetch_count_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   assign bus.fetch_count    = fetch_count_q;
   assign bus.redirect_count = redirect_count_q;
`else
   logic unused_advance;
   assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// against a spec-level model of the PC, link register and fault flag.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   ifetch_unit_if #(.IMEM_ADDR_WIDTH(14)) bus ();

   ifetch_unit #(.IMEM_ADDR_WIDTH(14), .RESET_PC(32'h0000_0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Synchronous instruction memory, one cycle read latency.
   logic [31:0] mem [0:16383];
   always @(posedge clock) bus.imem_rdata <= mem[bus.imem_addr];

   // Reference model: mode 0 = priming, 1 = running, 2 = faulted.
   int          m_mode = 0;
   logic [31:0] m_pc = 0, m_opc = 0, m_fetch = 0, m_redir = 0;
   bit          m_fault = 0;

   function automatic logic [31:0] m_next();
      logic [31:0] seq;
      logic [31:0] ins;
      seq = m_pc + 32'd4;
      ins = mem[m_pc[15:2]];
      if (bus.jr) return bus.read_data_1;
      if (bus.jmp || bus.jal) return {seq[31:28], ins[25:0], 2'b00};
      if ((bus.branch && bus.zero) || (bus.nbranch && !bus.zero)) return bus.addr_result;
      return seq;
   endfunction

   function automatic logic [13:0] m_exp_addr();
      logic [31:0] t;
      if (!reset) return 14'd0;
      if (m_mode == 1 && !bus.stall) t = m_next();
      else t = m_pc;
      return t[15:2];
   endfunction

   task automatic model_step();
      logic [31:0] seq, tgt;
      bit nonseq;
      if (!reset) begin
         m_mode = 0; m_pc = 0; m_opc = 0; m_fault = 0; m_fetch = 0; m_redir = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1 && !bus.stall) begin
         seq    = m_pc + 32'd4;
         tgt    = m_next();
         nonseq = bus.jr || bus.jmp || bus.jal ||
                  (bus.branch && bus.zero) || (bus.nbranch && !bus.zero);
         m_fetch = m_fetch + 32'd1;
         if (tgt != seq) m_redir = m_redir + 32'd1;
         if (bus.jal) m_opc = seq;
         if (nonseq && tgt[1:0] != 2'b00) begin
            m_mode = 2; m_fault = 1;
         end else begin
            m_pc = tgt;
         end
      end
   endtask

   // Driver: called at a falling edge; inputs settle 1 time unit later.
   task automatic apply(input bit rst, input bit st, input bit br, input bit nbr,
                        input bit z, input bit j, input bit jl, input bit jrr,
                        input logic [31:0] ar, input logic [31:0] rd1);
      reset = rst;  bus.stall = st; bus.branch = br; bus.nbranch = nbr;
      bus.zero = z; bus.jmp = j;    bus.jal = jl;    bus.jr = jrr;
      bus.addr_result = ar; bus.read_data_1 = rd1;
      #1;
   endtask

   task automatic idle();
      apply(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic run_to(input logic [31:0] addr);
      apply(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, addr);
      tick();
   endtask

   task automatic test_reset();
      mem[0] = 32'h2001_0005;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      tests_run++; if (bus.imem_addr !== 14'd0) begin tests_failed++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
      tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
      tick(); tick();
      tests_run++; if (bus.pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", bus.pc); end
      tests_run++; if (bus.opcplus4 !== 32'h0) begin tests_failed++; $display("FAIL reset_opc: got %h want 0", bus.opcplus4); end
      tests_run++; if (bus.fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %b want 0", bus.fetch_fault); end
      tests_run++; if (bus.dbg_state !== S_PRIME) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, S_PRIME); end
      idle();
      tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL prime_valid: got %b want 0", bus.instr_valid); end
      tests_run++; if (bus.imem_addr !== 14'd0) begin tests_failed++; $display("FAIL prime_addr: got %h want 0", bus.imem_addr); end
      tick();
      tests_run++; if (bus.instr_valid !== 1'b1) begin tests_failed++; $display("FAIL run_valid: got %b want 1", bus.instr_valid); end
      tests_run++; if (bus.instruction !== 32'h2001_0005) begin tests_failed++; $display("FAIL first_instr: got %h want 20010005", bus.instruction); end
      tests_run++; if (bus.pc !== 32'h0) begin tests_failed++; $display("FAIL first_pc: got %h want 0", bus.pc); end
      tests_run++; if (bus.imem_addr !== 14'd1) begin tests_failed++; $display("FAIL seq_addr1: got %h want 1", bus.imem_addr); end
      tick();
      tests_run++; if (bus.imem_addr !== 14'd2) begin tests_failed++; $display("FAIL seq_addr2: got %h want 2", bus.imem_addr); end
      tests_run++; if (bus.branch_base_addr !== 32'h8) begin tests_failed++; $display("FAIL bba: got %h want 8", bus.branch_base_addr); end
   endtask

   task automatic test_branch();
      logic [31:0] want [4];
      want = '{32'h14, 32'h40, 32'h40, 32'h14};
      for (int i = 0; i < 4; i++) begin
         run_to(32'h10);
         apply(1, 0, !i[1], i[1], i[0], 0, 0, 0, 32'h40, 32'h0);
         tick();
         tests_run++;
         if (bus.pc !== want[i]) begin
            tests_failed++;
            $display("FAIL branch_case%0d: got pc %h want %h", i, bus.pc, want[i]);
         end
      end
   endtask

   task automatic test_jal();
      mem[8] = {6'h03, 26'h40};
      run_to(32'h20);
      apply(1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
      tick();
      tests_run++; if (bus.pc !== 32'h100) begin tests_failed++; $display("FAIL jal_pc: got %h want 100", bus.pc); end
      tests_run++; if (bus.opcplus4 !== 32'h24) begin tests_failed++; $display("FAIL jal_link: got %h want 24", bus.opcplus4); end
      for (int k = 0; k < 5; k++) begin
         idle();
         tick();
         tests_run++;
         if (bus.opcplus4 !== 32'h24 || bus.pc !== 32'h100 + 32'(4 * (k + 1))) begin
            tests_failed++;
            $display("FAIL jal_hold%0d: got opc %h pc %h want opc 24 pc %h", k, bus.opcplus4, bus.pc, 32'h100 + 32'(4 * (k + 1)));
         end
      end
   endtask

   task automatic test_jr_fault();
      run_to(32'h200);
      apply(1, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h1000);
      tick();
      tests_run++; if (bus.pc !== 32'h1000) begin tests_failed++; $display("FAIL jr_priority: got %h want 1000", bus.pc); end
      apply(1, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h1002);
      tick();
      tests_run++; if (bus.fetch_fault !== 1'b1) begin tests_failed++; $display("FAIL fault_set: got %b want 1", bus.fetch_fault); end
      tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL fault_valid: got %b want 0", bus.instr_valid); end
      tests_run++; if (bus.pc !== 32'h1000) begin tests_failed++; $display("FAIL fault_pc: got %h want 1000", bus.pc); end
      tests_run++; if (bus.opcplus4 !== 32'h1004) begin tests_failed++; $display("FAIL fault_link: got %h want 1004", bus.opcplus4); end
      for (int k = 0; k < 3; k++) begin
         apply(1, 0, 1, 0, 1, 0, 1, 1, 32'h40, 32'h2000);
         tick();
         tests_run++;
         if (bus.pc !== 32'h1000 || bus.fetch_fault !== 1'b1 || bus.imem_addr !== 14'h400 || bus.opcplus4 !== 32'h1004) begin
            tests_failed++;
            $display("FAIL fault_frozen%0d: got pc %h fault %b addr %h opc %h want 1000 1 400 1004", k, bus.pc, bus.fetch_fault, bus.imem_addr, bus.opcplus4);
         end
      end
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      tick();
      tests_run++;
      if (bus.pc !== 32'h0 || bus.fetch_fault !== 1'b0 || bus.dbg_state !== S_PRIME) begin
         tests_failed++;
         $display("FAIL fault_reset: got pc %h fault %b state %0d want 0 0 %0d", bus.pc, bus.fetch_fault, bus.dbg_state, S_PRIME);
      end
      idle(); tick();
   endtask

   task automatic test_stall();
      logic [31:0] keep_opc;
      run_to(32'h30);
      keep_opc = m_opc;
      for (int k = 0; k < 3; k++) begin
         apply(1, 1, 1, 0, 1, 0, 1, 0, 32'h80, 32'h0);
         tests_run++; if (bus.imem_addr !== 14'd12) begin tests_failed++; $display("FAIL stall_addr%0d: got %h want c", k, bus.imem_addr); end
         tick();
         tests_run++;
         if (bus.pc !== 32'h30 || bus.instruction !== mem[12] || bus.opcplus4 !== keep_opc || bus.instr_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold%0d: got pc %h instr %h opc %h valid %b want 30 %h %h 1", k, bus.pc, bus.instruction, bus.opcplus4, bus.instr_valid, mem[12], keep_opc);
         end
      end
      apply(1, 0, 1, 0, 1, 0, 0, 0, 32'h80, 32'h0);
      tick();
      tests_run++; if (bus.pc !== 32'h80) begin tests_failed++; $display("FAIL stall_release: got %h want 80", bus.pc); end
   endtask

   task automatic test_reset_in_stall();
      run_to(32'h44);
      apply(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      tick();
      apply(0, 1, 1, 0, 1, 0, 1, 0, 32'h80, 32'h0);
      tick();
      tests_run++;
      if (bus.pc !== 32'h0 || bus.fetch_fault !== 1'b0 || bus.dbg_state !== S_PRIME || bus.opcplus4 !== 32'h0) begin
         tests_failed++;
         $display("FAIL stall_reset: got pc %h fault %b state %0d opc %h want 0 0 %0d 0", bus.pc, bus.fetch_fault, bus.dbg_state, bus.opcplus4, S_PRIME);
      end
      idle(); tick();
   endtask

`ifdef IFETCH_PERF_CNT_EN
   task automatic test_counters();
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      tick();
      tests_run++;
      if (bus.fetch_count !== 32'd0 || bus.redirect_count !== 32'd0) begin
         tests_failed++;
         $display("FAIL cnt_reset: got %0d/%0d want 0/0", bus.fetch_count, bus.redirect_count);
      end
      idle(); tick();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) apply(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h400);
         else if (i == 7) apply(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h800);
         else idle();
         tick();
      end
      tests_run++;
      if (bus.fetch_count !== 32'd10 || bus.redirect_count !== 32'd2) begin
         tests_failed++;
         $display("FAIL cnt_values: got %0d/%0d want 10/2", bus.fetch_count, bus.redirect_count);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] r_ar, r_rd, r_bits;
      bit          rst;
      int          kind;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      tick();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 39) != 0);
         if (m_fault && $urandom_range(0, 3) == 0) rst = 0;
         r_ar = $urandom(); r_rd = $urandom(); r_bits = $urandom();
         r_ar[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
         r_rd[1:0] = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
         kind = $urandom_range(0, 9);
         if ($urandom_range(0, 3) != 0) r_bits[7:3] = 5'b0;
         apply(rst, $urandom_range(0, 5) == 0,
               kind == 3 || r_bits[3], kind == 4 || r_bits[4], r_bits[0],
               kind == 1 || r_bits[5], kind == 2 || r_bits[6], kind == 0 || r_bits[7],
               r_ar, r_rd);
         tests_run++;
         if (bus.imem_addr !== m_exp_addr()) begin
            tests_failed++;
            $display("FAIL rnd_addr@%0d: got %h want %h", n, bus.imem_addr, m_exp_addr());
         end
         tick();
         tests_run++;
         if (bus.pc !== m_pc || bus.opcplus4 !== m_opc || bus.fetch_fault !== m_fault ||
             bus.instr_valid !== (reset && m_mode == 1)) begin
            tests_failed++;
            $display("FAIL rnd_state@%0d: got pc %h opc %h fault %b valid %b want %h %h %b %b", n,
                     bus.pc, bus.opcplus4, bus.fetch_fault, bus.instr_valid, m_pc, m_opc, m_fault, reset && m_mode == 1);
         end
         if (bus.instr_valid === 1'b1) begin
            tests_run++;
            if (bus.instruction !== mem[m_pc[15:2]]) begin
               tests_failed++;
               $display("FAIL rnd_instr@%0d: got %h want %h", n, bus.instruction, mem[m_pc[15:2]]);
            end
         end
`ifdef IFETCH_PERF_CNT_EN
         tests_run++;
         if (bus.fetch_count !== m_fetch || bus.redirect_count !== m_redir) begin
            tests_failed++;
            $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", n, bus.fetch_count, bus.redirect_count, m_fetch, m_redir);
         end
`endif
      end
   endtask

   initial begin
      for (int a = 0; a < 16384; a++) mem[a] = $urandom();
      test_reset();
      test_branch();
      test_jal();
      test_jr_fault();
      test_stall();
      test_reset_in_stall();
`ifdef IFETCH_PERF_CNT_EN
      test_counters();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
